// File: rtl/act_feeder_pkg.sv
// Shared types and helpers for the activation row feeder.
// Holds the FSM state encoding and the row-index width rule.
package act_feeder_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE,
    FEED_ROWS,
    FEED_SHADOW,
    FEED_DONE
  } feeder_state_t;

  // Row index needs at least one bit even for a single-row array.
  function automatic int unsigned row_idx_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/act_row_feeder_if.sv
// Compressed-activation stream from the activation buffer into the feeder.
// A beat transfers on a cycle where in_valid and in_ready are both 1; the source holds
// in_valid/in_data stable until that cycle, and in_ready may depend combinationally on feeder state.
interface act_row_feeder_if #(
  parameter int width = 17
) ();
  logic             in_valid;
  logic [width-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/act_row_hold_reg.sv
// Enable-loaded register holding the last value driven onto one row's data bus,
// so the bus does not toggle while no beat targets that row.
module act_row_hold_reg #(
  parameter int width = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [width-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/act_row_feeder.sv
// Drains the compressed-activation stream row by row into the PE AFIFOs, broadcasting
// each beat across the columns of its row, then optionally one extra row into the shadow AFIFOs.
module act_row_feeder
  import act_feeder_pkg::*;
#(
  parameter int num_pe_row           = 1,
  parameter int num_pe_col           = 1,
  parameter int total_num_pe         = num_pe_row * num_pe_col,
  parameter int activation_width     = 16,
  parameter int compressed_act_width = activation_width + 1,
  parameter int afifo_depth          = 8,
  parameter int len_width            = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            i_cfg_start,
  input  logic [len_width-1:0]                            i_cfg_row_len,
  input  logic                                            i_cfg_shadow_en,
  act_row_feeder_if.slave                                 s_in,
  input  logic [total_num_pe-1:0]                         i_pe_ctrl_afifo_full,
  output logic [num_pe_row-1:0][compressed_act_width-1:0] o_pe_data_compressed_act_in,
  output logic [total_num_pe-1:0]                         o_pe_ctrl_afifo_write,
  output logic [num_pe_col-1:0][compressed_act_width-1:0] o_pe_data_last_row_shadow_afifo_data_in,
  output logic [num_pe_col-1:0]                           o_pe_ctrl_last_row_shadow_afifo_write,
  output logic                                            o_busy,
  output logic                                            o_done,
  output logic                                            o_cfg_err,
  output feeder_state_t                                   o_state
);

  localparam int RW = row_idx_width(num_pe_row);

  feeder_state_t          r_state;
  logic [RW-1:0]          r_row_idx;
  logic [len_width-1:0]   r_elem_cnt;
  logic [len_width-1:0]   r_row_len;
  logic                   r_shadow_en;
  logic                   r_cfg_err;

  logic                   w_row_full;
  logic                   w_ready;
  logic                   w_fire;
  logic                   w_last_elem;
  logic                   w_last_row;
  logic                   w_shadow_fire;
  logic [num_pe_row-1:0]  w_row_fire;
  logic [num_pe_row-1:0][compressed_act_width-1:0] w_row_hold;
  logic [compressed_act_width-1:0]                 w_shadow_hold;

  // A single full PE in the target row stalls the whole row broadcast.
  assign w_row_full  = |i_pe_ctrl_afifo_full[r_row_idx * num_pe_col +: num_pe_col];
  assign w_ready     = !rst && ((r_state == FEED_ROWS && !w_row_full) || r_state == FEED_SHADOW);
  assign w_fire      = s_in.in_valid && w_ready;
  assign w_last_elem = (r_elem_cnt == r_row_len - len_width'(1));
  assign w_last_row  = (r_row_idx == RW'(num_pe_row - 1));
  assign w_shadow_fire = w_fire && (r_state == FEED_SHADOW);

  assign s_in.in_ready = w_ready;

  for (genvar r = 0; r < num_pe_row; r++) begin : g_row
    assign w_row_fire[r] = w_fire && (r_state == FEED_ROWS) && (r_row_idx == RW'(r));

    act_row_hold_reg #(.width(compressed_act_width)) u_hold (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_row_fire[r]),
      .i_d  (s_in.in_data),
      .o_q  (w_row_hold[r])
    );

    assign o_pe_data_compressed_act_in[r] = w_row_fire[r] ? s_in.in_data : w_row_hold[r];

    for (genvar c = 0; c < num_pe_col; c++) begin : g_col
      assign o_pe_ctrl_afifo_write[c + r * num_pe_col] = w_row_fire[r];
    end
  end

  act_row_hold_reg #(.width(compressed_act_width)) u_shadow_hold (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_shadow_fire),
    .i_d  (s_in.in_data),
    .o_q  (w_shadow_hold)
  );

  for (genvar c = 0; c < num_pe_col; c++) begin : g_shadow
    assign o_pe_ctrl_last_row_shadow_afifo_write[c]   = w_shadow_fire;
    assign o_pe_data_last_row_shadow_afifo_data_in[c] = w_shadow_fire ? s_in.in_data : w_shadow_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FEED_IDLE;
      r_row_idx   <= '0;
      r_elem_cnt  <= '0;
      r_row_len   <= '0;
      r_shadow_en <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      case (r_state)
        FEED_IDLE: begin
          if (i_cfg_start) begin
            if (i_cfg_row_len > len_width'(afifo_depth)) begin
              r_cfg_err <= 1'b1;
            end else if (i_cfg_row_len == '0) begin
              r_cfg_err <= 1'b0;
              r_state   <= FEED_DONE;
            end else begin
              r_cfg_err   <= 1'b0;
              r_row_len   <= i_cfg_row_len;
              r_shadow_en <= i_cfg_shadow_en;
              r_row_idx   <= '0;
              r_elem_cnt  <= '0;
              r_state     <= FEED_ROWS;
            end
          end
        end
        FEED_ROWS: begin
          if (w_fire) begin
            if (w_last_elem) begin
              r_elem_cnt <= '0;
              if (!w_last_row) begin
                r_row_idx <= r_row_idx + RW'(1);
              end else begin
                r_state <= r_shadow_en ? FEED_SHADOW : FEED_DONE;
              end
            end else begin
              r_elem_cnt <= r_elem_cnt + len_width'(1);
            end
          end
        end
        FEED_SHADOW: begin
          if (w_fire) begin
            if (w_last_elem) begin
              r_elem_cnt <= '0;
              r_state    <= FEED_DONE;
            end else begin
              r_elem_cnt <= r_elem_cnt + len_width'(1);
            end
          end
        end
        FEED_DONE: begin
          r_state <= FEED_IDLE;
        end
        default: begin
          r_state <= FEED_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = (r_state != FEED_IDLE);
  assign o_done    = (r_state == FEED_DONE);
  assign o_cfg_err = r_cfg_err;
  assign o_state   = r_state;

endmodule

// File: tb/tb_act_row_feeder.sv
// Bench for act_row_feeder on a 2x2 PE array with depth-4 AFIFOs, comparing every cycle
// against a beat-index model: beat k of a run lands in row k/row_len, or the shadow row past the array.
module tb_act_row_feeder;
  import act_feeder_pkg::*;

  localparam int R = 2;
  localparam int C = 2;
  localparam int T = R * C;
  localparam int W = 17;
  localparam int D = 4;
  localparam int L = 8;

  logic                clk;
  logic                rst;
  logic                cfg_start;
  logic [L-1:0]        cfg_row_len;
  logic                cfg_shadow_en;
  logic [T-1:0]        afifo_full;
  logic [R-1:0][W-1:0] pe_data;
  logic [T-1:0]        afifo_write;
  logic [C-1:0][W-1:0] sh_data;
  logic [C-1:0]        sh_write;
  logic                busy;
  logic                done;
  logic                cfg_err;
  feeder_state_t       state;

  act_row_feeder_if #(.width(W)) act_if ();

  act_row_feeder #(
    .num_pe_row(R), .num_pe_col(C), .activation_width(W - 1),
    .afifo_depth(D), .len_width(L)
  ) dut (
    .clk                                     (clk),
    .rst                                     (rst),
    .i_cfg_start                             (cfg_start),
    .i_cfg_row_len                           (cfg_row_len),
    .i_cfg_shadow_en                         (cfg_shadow_en),
    .s_in                                    (act_if.slave),
    .i_pe_ctrl_afifo_full                    (afifo_full),
    .o_pe_data_compressed_act_in             (pe_data),
    .o_pe_ctrl_afifo_write                   (afifo_write),
    .o_pe_data_last_row_shadow_afifo_data_in (sh_data),
    .o_pe_ctrl_last_row_shadow_afifo_write   (sh_write),
    .o_busy                                  (busy),
    .o_done                                  (done),
    .o_cfg_err                               (cfg_err),
    .o_state                                 (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  int           m_len;
  int           m_total;
  int           m_k;
  bit           m_sh;
  bit           m_active;
  bit           m_done_pend;
  bit           m_err;
  logic [W-1:0] m_hold [R+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_len = 0; m_total = 0; m_k = 0; m_sh = 0;
    m_active = 0; m_done_pend = 0; m_err = 0;
    for (int i = 0; i <= R; i++) m_hold[i] = '0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model past the edge.
  task automatic step(input bit st, input int len, input bit sh, input bit v,
                      input logic [W-1:0] d, input logic [T-1:0] full, input bit rs);
    int           tgt;
    bit           exp_ready;
    bit           fire;
    logic [T-1:0] exp_wr;
    logic [C-1:0] exp_sh_wr;
    logic [W-1:0] exp_data [R+1];
    @(negedge clk);
    rst = rs; cfg_start = st; cfg_row_len = L'(len); cfg_shadow_en = sh;
    act_if.in_valid = v; act_if.in_data = d; afifo_full = full;
    #1;
    tgt = m_active ? (m_k / m_len) : 0;
    exp_ready = 0;
    if (!rs && m_active) begin
      if (tgt >= R) exp_ready = 1;
      else exp_ready = ((full >> (tgt * C)) & ((1 << C) - 1)) == 0;
    end
    fire = v && exp_ready;
    exp_wr = '0; exp_sh_wr = '0;
    for (int i = 0; i <= R; i++) exp_data[i] = m_hold[i];
    if (fire) begin
      if (tgt < R) exp_wr = T'(((1 << C) - 1) << (tgt * C));
      else exp_sh_wr = '1;
      exp_data[tgt < R ? tgt : R] = d;
    end
    chk("in_ready", act_if.in_ready, exp_ready);
    chk("afifo_write", afifo_write, exp_wr);
    chk("row0_data", pe_data[0], exp_data[0]);
    chk("row1_data", pe_data[1], exp_data[1]);
    chk("shadow_write", sh_write, exp_sh_wr);
    chk("shadow_data0", sh_data[0], exp_data[R]);
    chk("shadow_data1", sh_data[1], exp_data[R]);
    chk("done", done, m_done_pend);
    chk("busy", busy, m_active || m_done_pend);
    chk("cfg_err", cfg_err, m_err);
    if (rs) begin
      model_reset();
    end else begin
      bit was_active = m_active;
      bit was_done   = m_done_pend;
      if (fire) begin
        m_hold[tgt < R ? tgt : R] = d;
        m_k++;
        if (m_k == m_total) begin
          m_active = 0;
          m_done_pend = 1;
        end
      end
      if (was_done) m_done_pend = 0;
      if (st && !was_active && !was_done) begin
        if (len > D) m_err = 1;
        else if (len == 0) begin
          m_err = 0; m_done_pend = 1;
        end else begin
          m_err = 0; m_len = len; m_sh = sh; m_k = 0;
          m_total = len * (R + (sh ? 1 : 0));
          m_active = 1;
        end
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0, 0);
  endtask

  // Drive the remaining beats of the current run (data = base + beat index unless randomised).
  task automatic finish_job(input bit rnd, input logic [W-1:0] base);
    int           budget = 0;
    bit           v;
    logic [T-1:0] full;
    logic [W-1:0] d;
    bit           st;
    while ((m_active || m_done_pend) && budget < 300) begin
      v    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      full = (rnd && $urandom_range(0, 2) == 0) ? T'($urandom_range(0, 15)) : '0;
      d    = rnd ? W'($urandom) : base + W'(m_k);
      st   = rnd && ($urandom_range(0, 7) == 0);
      step(st, $urandom_range(1, D), 1'b0, v, d, full, 0);
      budget++;
    end
    chk("job_bound", budget < 300, 1);
    idle();
  endtask

  task automatic run_job(input int len, input bit sh, input bit rnd, input logic [W-1:0] base);
    step(1, len, sh, 0, '0, '0, 0);
    finish_job(rnd, base);
  endtask

  initial begin
    model_reset();
    rst = 1; cfg_start = 0; cfg_row_len = '0; cfg_shadow_en = 0;
    act_if.in_valid = 0; act_if.in_data = '0; afifo_full = '0;
    step(0, 0, 0, 0, '0, '0, 1);
    step(0, 0, 0, 0, '0, '0, 1);
    idle();

    // basic back-to-back run, beats 0x01..0x06
    run_job(3, 0, 0, W'(1));

    // stall on row 0 during the second beat
    step(1, 3, 0, 0, '0, '0, 0);
    step(0, 0, 0, 1, W'(1), '0, 0);
    step(0, 0, 0, 1, W'(2), T'(2), 0);
    step(0, 0, 0, 1, W'(2), '0, 0);
    finish_job(0, W'(1));

    // shadow row, beats 0x11..0x16
    run_job(2, 1, 0, W'('h11));

    // config edges: empty run, oversize length, then a good start clears the error
    run_job(0, 0, 0, '0);
    step(1, 5, 0, 1, W'(7), '0, 0);
    idle();
    idle();
    run_job(1, 1, 0, W'('h40));

    // start pulse while busy must not change the beat count
    step(1, 2, 0, 0, '0, '0, 0);
    step(0, 0, 0, 1, W'('h30), '0, 0);
    step(1, 1, 1, 1, W'('h31), '0, 0);
    finish_job(0, W'('h30));

    // reset mid-run after two beats, then a fresh run
    step(1, 3, 0, 0, '0, '0, 0);
    step(0, 0, 0, 1, W'('h21), '0, 0);
    step(0, 0, 0, 1, W'('h22), '0, 0);
    step(0, 0, 0, 1, W'('h23), '0, 1);
    idle();
    run_job(3, 0, 0, W'('h50));

    // randomised runs
    for (int n = 0; n < 40; n++) begin
      run_job($urandom_range(1, D), $urandom_range(0, 1), 1, '0);
      if ($urandom_range(0, 9) == 0) begin
        step(1, $urandom_range(D + 1, 20), 0, 0, '0, '0, 0);
        idle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
